// File: rtl/common_dffram_mwnr_pkg.sv
// Shared definitions for the multi-port DFF register-file RAM.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package common_dffram_mwnr_pkg;

    // Re-initialisation engine states
    typedef enum logic {
        INIT_IDLE  = 1'b0,
        INIT_SWEEP = 1'b1
    } init_state_t;

    // Number of entries addressed by an address of the given width
    function automatic int unsigned ram_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/common_dffram_wrsel.sv
// Write-port priority selector: collapses per-port hits into one enable and one data word.
// Latency: combinational.
// Backpressure: none; the highest-index hitting port always wins.
module common_dffram_wrsel #(
    parameter int PORTS = 2,
    parameter int WIDTH = 32
) (
    input  logic [PORTS-1:0]       hit,
    input  logic [PORTS*WIDTH-1:0] data,
    output logic                   en,
    output logic [WIDTH-1:0]       sel_data
);

    // Ascending scan so a later (higher-index) port overrides earlier ones
    always_comb begin
        en       = 1'b0;
        sel_data = '0;
        for (int w = 0; w < PORTS; w++) begin
            if (hit[w]) begin
                en       = 1'b1;
                sel_data = data[w*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/stdmacro_dffe.sv
// Enabled D flip-flop with synchronous reset to a per-instance value.
// Latency: 1 cycle from d/en to q.
// Backpressure: none; q holds whenever en is low.
module stdmacro_dffe #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // State register: reset value, then load d when enabled
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/common_dffram_mwnr.sv
// Multi-write/multi-read DFF register-file RAM with a sequenced re-init sweep.
// Latency: reads combinational or 1 cycle registered; writes visible after the edge.
// Backpressure: wr_ready low while sweeping; writes offered then are dropped.
module common_dffram_mwnr
    import common_dffram_mwnr_pkg::*;
#(
    parameter int RAM_DATA_WIDTH      = 32,
    parameter int RAM_ADDR_WIDTH      = 5,
    parameter int RAM_WRITE_PORTS     = 2,
    parameter int RAM_READ_PORTS      = 4,
    parameter bit RAM_READ_REGISTERED = 1'b1,
    parameter bit RAM_WRITE_BYPASS    = 1'b1,
    parameter logic [ram_depth(RAM_ADDR_WIDTH)*RAM_DATA_WIDTH-1:0] RAM_RESET_VALUE = '0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [RAM_WRITE_PORTS-1:0]             wr_en,
    input  logic [RAM_WRITE_PORTS*RAM_ADDR_WIDTH-1:0] wr_addr,
    input  logic [RAM_WRITE_PORTS*RAM_DATA_WIDTH-1:0] wr_data,
    output logic                                   wr_ready,
    input  logic [RAM_READ_PORTS-1:0]              rd_en,
    input  logic [RAM_READ_PORTS*RAM_ADDR_WIDTH-1:0]  rd_addr,
    output logic [RAM_READ_PORTS*RAM_DATA_WIDTH-1:0]  rd_data,
    input  logic                                   init_req,
    output logic                                   init_busy,
    output logic                                   init_done
);

    localparam int A     = RAM_ADDR_WIDTH;
    localparam int D     = RAM_DATA_WIDTH;
    localparam int W     = RAM_WRITE_PORTS;
    localparam int R     = RAM_READ_PORTS;
    localparam int DEPTH = int'(ram_depth(A));
    localparam logic [A-1:0] LAST = A'(DEPTH - 1);

    init_state_t    state;
    logic [A-1:0]   sweep_cnt;
    logic           done_q;
    logic [W-1:0]   wr_live;
    logic [D-1:0]   mem [DEPTH];

    // Sweep sequencer: one entry per cycle, pulse done after the last entry
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT_IDLE;
            sweep_cnt <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                INIT_IDLE: begin
                    if (init_req) begin
                        state     <= INIT_SWEEP;
                        sweep_cnt <= '0;
                    end
                end
                INIT_SWEEP: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == LAST) begin
                        state  <= INIT_IDLE;
                        done_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign init_busy = (state == INIT_SWEEP);
    assign init_done = done_q;
    assign wr_ready  = ~init_busy;

    // User writes are discarded outright while the sweep owns the array
    assign wr_live = wr_en & {W{~init_busy}};

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        logic [W-1:0] hit;
        logic         sel_en;
        logic [D-1:0] sel_dat;
        logic         sweep_hit;
        logic         ent_en;
        logic [D-1:0] ent_d;

        // Per-port address match against this entry
        always_comb begin
            hit = '0;
            for (int w = 0; w < W; w++) begin
                hit[w] = wr_live[w] && (wr_addr[w*A +: A] == A'(e));
            end
        end

        common_dffram_wrsel #(
            .PORTS (W),
            .WIDTH (D)
        ) u_wrsel (
            .hit      (hit),
            .data     (wr_data),
            .en       (sel_en),
            .sel_data (sel_dat)
        );

        // Sweep and user writes never coincide: user writes are gated by busy
        assign sweep_hit = init_busy && (sweep_cnt == A'(e));
        assign ent_en    = sel_en | sweep_hit;
        assign ent_d     = sweep_hit ? RAM_RESET_VALUE[e*D +: D] : sel_dat;

        stdmacro_dffe #(
            .WIDTH       (D),
            .RESET_VALUE (RAM_RESET_VALUE[e*D +: D])
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (ent_en),
            .d     (ent_d),
            .q     (mem[e])
        );
    end

    if (RAM_READ_REGISTERED) begin : g_rd_reg
        for (genvar r = 0; r < R; r++) begin : g_port
            logic [A-1:0] ra;
            logic [D-1:0] rd_next;
            logic [D-1:0] rd_q;

            assign ra = rd_addr[r*A +: A];

            if (RAM_WRITE_BYPASS) begin : g_byp
                logic [W-1:0] bhit;
                logic         byp_en;
                logic [D-1:0] byp_dat;

                // Writers landing on this read address at the coming edge
                always_comb begin
                    bhit = '0;
                    for (int w = 0; w < W; w++) begin
                        bhit[w] = wr_live[w] && (wr_addr[w*A +: A] == ra);
                    end
                end

                common_dffram_wrsel #(
                    .PORTS (W),
                    .WIDTH (D)
                ) u_bypsel (
                    .hit      (bhit),
                    .data     (wr_data),
                    .en       (byp_en),
                    .sel_data (byp_dat)
                );

                // Forward the value that the array will hold after this edge
                always_comb begin
                    rd_next = mem[ra];
                    if (init_busy && (sweep_cnt == ra)) begin
                        rd_next = RAM_RESET_VALUE[ra*D +: D];
                    end else if (byp_en) begin
                        rd_next = byp_dat;
                    end
                end
            end else begin : g_nobyp
                assign rd_next = mem[ra];
            end

            // Read register: capture on rd_en, otherwise hold
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_q <= '0;
                end else if (rd_en[r]) begin
                    rd_q <= rd_next;
                end
            end

            assign rd_data[r*D +: D] = rd_q;
        end
    end else begin : g_rd_comb
        logic unused_rd_en;
        assign unused_rd_en = ^rd_en;
        for (genvar r = 0; r < R; r++) begin : g_port
            assign rd_data[r*D +: D] = mem[rd_addr[r*A +: A]];
        end
    end

endmodule

// File: doc/common_dffram_mwnr.md
# common_dffram_mwnr

Parametrised DFF-based register-file RAM with a configurable number of write and read ports and selectable combinational or registered reads. Registered mode has optional write-to-read bypass. A built-in sequenced re-initialisation engine restores every entry to its reset value without asserting the global reset. It is the general storage primitive for register files, rename tables and small lookup tables in the core, and it supersedes fixed-port DFF RAMs.

## Interface
Parameters:
- `RAM_DATA_WIDTH`, 32: bits per entry.
- `RAM_ADDR_WIDTH`, 5: address bits; depth = 2^`RAM_ADDR_WIDTH`.
- `RAM_WRITE_PORTS`, 2: number of write ports W (≥1).
- `RAM_READ_PORTS`, 4: number of read ports R (≥1).
- `RAM_READ_REGISTERED`, 1: 0 = combinational read, 1 = registered read (1-cycle latency).
- `RAM_WRITE_BYPASS`, 1: registered mode only; 1 = same-cycle write data is forwarded to a read of the same address.
- `RAM_RESET_VALUE`, all zeros: depth×`RAM_DATA_WIDTH` flat vector; entry i occupies bits [i×D +: D].

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high reset.
- `wr_en`, input, W: per-port write enable.
- `wr_addr`, input, W×A: packed write addresses; port w occupies [w×A +: A].
- `wr_data`, input, W×D: packed write data.
- `wr_ready`, output, 1: writes accepted; equals ~`init_busy`.
- `rd_en`, input, R: per-port read enable; registered mode only, ignored otherwise.
- `rd_addr`, input, R×A: packed read addresses.
- `rd_data`, output, R×D: packed read data.
- `init_req`, input, 1: one-cycle request to start re-initialisation.
- `init_busy`, output, 1: sweep in progress.
- `init_done`, output, 1: one-cycle pulse when the sweep completes.

## Operation
- Reset: all entries load `RAM_RESET_VALUE`; registered `rd_data` = 0; FSM = IDLE; `init_busy` = 0; `init_done` = 0; sweep counter = 0.
- Writes:
  - Port w writes `wr_data[w]` to `wr_addr[w]` at the edge when `wr_en[w]` is high and `init_busy` is 0.
  - Writes issued while `init_busy` is high are dropped, not queued.
  - Multiple ports writing the same address in one cycle: the highest-index port wins.
- Combinational read: `rd_data[r]` = mem[`rd_addr[r]`], reflecting contents as of the last edge.
- Registered read:
  - When `rd_en[r]` is high at an edge, `rd_data[r]` loads mem[`rd_addr[r]`]; otherwise it holds.
  - With bypass = 1, a write committing at that same edge to the same address supplies the new value. This covers the winning (highest-index) writer and the sweep's clear write.
  - With bypass = 0, the read returns the pre-write value.
- Init FSM, states IDLE and SWEEP:
  - IDLE → SWEEP when `init_req` = 1; counter is cleared to 0.
  - In SWEEP, each edge writes entry[counter] ← `RAM_RESET_VALUE` entry, then counter increments.
  - SWEEP → IDLE after the edge that writes entry depth−1; `init_done` = 1 for the following cycle.
  - `init_req` during SWEEP is ignored.
  - Reads are allowed during SWEEP and return current, partially cleared contents.
- `reset` mid-sweep: immediate return to the reset state; no `init_done` pulse.
- Counter is A bits wide and wraps naturally; termination is detected at counter == depth−1.

## Timing
- Write to combinational read: the value is visible in the cycle after the write edge.
- Registered read latency: 1 cycle from `rd_en`/`rd_addr` sample to `rd_data`.
- Init sequence, for `init_req` sampled at edge k:
  - `init_busy` is high from after edge k to after edge k+depth, i.e. exactly depth cycles.
  - Entry i is cleared at edge k+1+i.
  - `init_done` is high in the cycle after edge k+depth, the same cycle `init_busy` falls.
  - `wr_ready` is low for exactly those depth cycles.
- A user write and `init_req` in the same cycle while IDLE: the write commits at that edge; the sweep starts after it.

## Structure
- Shared package/header: `RAM_DEPTH` derivation macro, FSM state encodings (IDLE = 1'b0, SWEEP = 1'b1), and a packed-port slice helper macro.
- Storage: reuse the existing `stdmacro_dffe`, one instance per entry.
  - Enable = any winning write or sweep hit.
  - d = priority-muxed write data or the reset value.
- One natural sub-module: `common_dffram_wrsel`. It is the per-entry write-port priority selector (W enables/data → one enable and one data) and is also reused by the bypass logic.

## Test plan
Common configuration: A=3, D=8, W=2, R=2, entry i reset value = i×0x11.
1. Reset, then combinational reads of addr 0..7 → 0x00, 0x11, … 0x77; in registered mode, `rd_data` = 0x00 until the first `rd_en`.
2. Same cycle: port0 writes addr 3 = 0xA5 and port1 writes addr 3 = 0x5A → a later read of addr 3 returns 0x5A.
3. Registered, bypass=1: write addr 2 = 0x77 and read addr 2 in the same cycle → `rd_data` = 0x77 next cycle. Repeat with bypass=0 → 0x22.
4. Fill all entries with 0xFF, pulse `init_req` → `init_busy` high 8 cycles; `wr_en` to addr 1 = 0x99 mid-sweep is dropped; `init_done` pulses once; all entries read back i×0x11.
5. Assert `reset` when the sweep counter = 4 → next cycle `init_busy` = 0, all entries equal reset values, no `init_done` pulse.
6. Combinational mode: write addr 5 = 0x3C → `rd_data` for addr 5 shows 0x55 before the edge and 0x3C after it.
